// File: rtl/axi_wr_arbiter.sv
// AXI write-channel arbiter: round-robin grants among NUM_MST masters for one
// AW/W burst at a time and routes each B response back to the master that
// issued the matching AW. The routing order is kept in a small FIFO.
module axi_wr_arbiter #(
    parameter int NUM_MST         = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int IDX_W          = ($clog2(NUM_MST) > 1) ? $clog2(NUM_MST) : 1,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_MST-1:0] mst_aw_valid_i,
    output logic [NUM_MST-1:0] mst_aw_ready_o,
    input  logic [NUM_MST-1:0] mst_w_valid_i,
    input  logic [NUM_MST-1:0] mst_w_last_i,
    output logic [NUM_MST-1:0] mst_w_ready_o,
    output logic [NUM_MST-1:0] mst_b_valid_o,
    input  logic [NUM_MST-1:0] mst_b_ready_i,
    output logic               slv_aw_valid_o,
    input  logic               slv_aw_ready_i,
    output logic               slv_w_valid_o,
    input  logic               slv_w_ready_i,
    input  logic               slv_b_valid_i,
    output logic               slv_b_ready_o,
    output logic [IDX_W-1:0]   aw_sel_o,
    output logic [IDX_W-1:0]   w_sel_o,
    output logic [CNT_W-1:0]   outstanding_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_grant;
    logic             req_any;
    logic [SUM_W-1:0] scan_sum;
    logic [IDX_W-1:0] scan_idx;

    logic [IDX_W-1:0] route_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             aw_hs;
    logic             w_hs;

    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head       = route_mem[rd_ptr];

    assign aw_hs = slv_aw_valid_o & slv_aw_ready_i;
    assign w_hs  = slv_w_valid_o & slv_w_ready_i;
    assign push  = aw_hs;
    assign pop   = slv_b_valid_i & slv_b_ready_o;

    // Round-robin pick: scan downward from the farthest offset so the requester
    // closest to rr_ptr (in wrapping order) is the last one written and wins.
    always_comb begin
        next_grant = rr_ptr;
        req_any    = 1'b0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            scan_sum = {1'b0, rr_ptr} + SUM_W'(i);
            if (scan_sum >= SUM_W'(NUM_MST)) begin
                scan_sum = scan_sum - SUM_W'(NUM_MST);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (mst_aw_valid_i[scan_idx]) begin
                next_grant = scan_idx;
                req_any    = 1'b1;
            end
        end
    end

    // Burst sequencer: grant in IDLE, forward AW in ADDR, forward W until WLAST.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any && !fifo_full) begin
                        grant <= next_grant;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs && mst_w_last_i[grant]) begin
                        state  <= IDLE;
                        rr_ptr <= (grant == IDX_W'(NUM_MST - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake steering; everything is forced low while reset is asserted so
    // stale FIFO or FSM contents cannot leak out before the first reset edge.
    always_comb begin
        mst_aw_ready_o = '0;
        mst_w_ready_o  = '0;
        mst_b_valid_o  = '0;
        slv_aw_valid_o = 1'b0;
        slv_w_valid_o  = 1'b0;
        slv_b_ready_o  = 1'b0;
        if (rst_ni) begin
            case (state)
                ADDR: begin
                    slv_aw_valid_o        = mst_aw_valid_i[grant];
                    mst_aw_ready_o[grant] = slv_aw_ready_i;
                end
                DATA: begin
                    slv_w_valid_o        = mst_w_valid_i[grant];
                    mst_w_ready_o[grant] = slv_w_ready_i;
                end
                default: ;
            endcase
            if (!fifo_empty) begin
                mst_b_valid_o[head] = slv_b_valid_i;
                slv_b_ready_o       = mst_b_ready_i[head];
            end
        end
    end

    assign aw_sel_o      = rst_ni ? grant : '0;
    assign w_sel_o       = rst_ni ? grant : '0;
    assign outstanding_o = rst_ni ? count : '0;

    // B-route FIFO pointers and occupancy; a push and pop together leave count alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // B-route storage: remembers which master owns each accepted AW.
    always_ff @(posedge clk_i) begin
        if (push) begin
            route_mem[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Testbench for axi_wr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model built on a queue.
module tb_axi_wr_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [N-1:0] mst_aw_valid_i;
    logic [N-1:0] mst_aw_ready_o;
    logic [N-1:0] mst_w_valid_i;
    logic [N-1:0] mst_w_last_i;
    logic [N-1:0] mst_w_ready_o;
    logic [N-1:0] mst_b_valid_o;
    logic [N-1:0] mst_b_ready_i;
    logic         slv_aw_valid_o;
    logic         slv_aw_ready_i;
    logic         slv_w_valid_o;
    logic         slv_w_ready_i;
    logic         slv_b_valid_i;
    logic         slv_b_ready_o;
    logic [1:0]   aw_sel_o;
    logic [1:0]   w_sel_o;
    logic [3:0]   outstanding_o;

    int tests  = 0;
    int failed = 0;

    // Reference model: is a burst owned, has its AW gone, who owns it,
    // where the next round-robin search starts, and the B ownership queue.
    bit m_busy;
    bit m_addr_done;
    int m_grant;
    int m_rr;
    int m_q[$];

    always #5 clk_i = ~clk_i;

    axi_wr_arbiter #(.NUM_MST(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .mst_aw_valid_i (mst_aw_valid_i),
        .mst_aw_ready_o (mst_aw_ready_o),
        .mst_w_valid_i  (mst_w_valid_i),
        .mst_w_last_i   (mst_w_last_i),
        .mst_w_ready_o  (mst_w_ready_o),
        .mst_b_valid_o  (mst_b_valid_o),
        .mst_b_ready_i  (mst_b_ready_i),
        .slv_aw_valid_o (slv_aw_valid_o),
        .slv_aw_ready_i (slv_aw_ready_i),
        .slv_w_valid_o  (slv_w_valid_o),
        .slv_w_ready_i  (slv_w_ready_i),
        .slv_b_valid_i  (slv_b_valid_i),
        .slv_b_ready_o  (slv_b_ready_o),
        .aw_sel_o       (aw_sel_o),
        .w_sel_o        (w_sel_o),
        .outstanding_o  (outstanding_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Random input pattern for one cycle, with an occasional reset pulse.
    task automatic applyStimulus();
        rst_ni         = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        mst_aw_valid_i = N'($urandom);
        mst_w_valid_i  = N'($urandom);
        mst_w_last_i   = N'($urandom) & N'($urandom);
        mst_b_ready_i  = N'($urandom);
        slv_aw_ready_i = 1'($urandom);
        slv_w_ready_i  = 1'($urandom);
        slv_b_valid_i  = 1'($urandom);
    endtask

    // Compare all outputs with the model, advance the model, then clock once.
    task automatic checkOutput();
        logic [N-1:0] e_awr;
        logic [N-1:0] e_wr;
        logic [N-1:0] e_bv;
        logic         e_sav;
        logic         e_swv;
        logic         e_sbr;
        logic [1:0]   e_sel;
        int           e_cnt;
        bit           do_pop;
        bit           do_push;
        int           c;
        e_awr = '0; e_wr = '0; e_bv = '0;
        e_sav = 1'b0; e_swv = 1'b0; e_sbr = 1'b0;
        e_sel = 2'd0; e_cnt = 0;
        do_pop = 1'b0; do_push = 1'b0;
        #1;
        if (rst_ni) begin
            e_sel = 2'(m_grant);
            e_cnt = m_q.size();
            if (m_busy && !m_addr_done) begin
                e_sav          = mst_aw_valid_i[m_grant];
                e_awr[m_grant] = slv_aw_ready_i;
            end
            if (m_busy && m_addr_done) begin
                e_swv         = mst_w_valid_i[m_grant];
                e_wr[m_grant] = slv_w_ready_i;
            end
            if (m_q.size() > 0) begin
                e_bv[m_q[0]] = slv_b_valid_i;
                e_sbr        = mst_b_ready_i[m_q[0]];
            end
        end
        check("aw_chan", 32'({slv_aw_valid_o, mst_aw_ready_o}), 32'({e_sav, e_awr}));
        check("w_chan",  32'({slv_w_valid_o, mst_w_ready_o}),   32'({e_swv, e_wr}));
        check("b_chan",  32'({slv_b_ready_o, mst_b_valid_o}),   32'({e_sbr, e_bv}));
        check("sel",     32'({aw_sel_o, w_sel_o}),              32'({e_sel, e_sel}));
        check("outstanding", 32'(outstanding_o), 32'(e_cnt));

        if (!rst_ni) begin
            m_busy = 1'b0; m_addr_done = 1'b0; m_grant = 0; m_rr = 0;
            m_q.delete();
        end else begin
            do_pop = (m_q.size() > 0) && slv_b_valid_i && mst_b_ready_i[m_q[0]];
            if (!m_busy) begin
                if (mst_aw_valid_i != '0 && m_q.size() < MAXO) begin
                    for (int k = 0; k < N; k++) begin
                        c = (m_rr + k) % N;
                        if (mst_aw_valid_i[c]) begin
                            m_grant = c;
                            break;
                        end
                    end
                    m_busy      = 1'b1;
                    m_addr_done = 1'b0;
                end
            end else if (!m_addr_done) begin
                if (mst_aw_valid_i[m_grant] && slv_aw_ready_i) begin
                    do_push     = 1'b1;
                    m_addr_done = 1'b1;
                end
            end else if (mst_w_valid_i[m_grant] && slv_w_ready_i && mst_w_last_i[m_grant]) begin
                m_busy = 1'b0;
                m_rr   = (m_grant + 1) % N;
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(m_grant);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Directed scenarios, then a long stretch of random traffic.
    initial begin
        m_busy = 1'b0; m_addr_done = 1'b0; m_grant = 0; m_rr = 0;
        rst_ni = 1'b0;
        mst_aw_valid_i = '0; mst_w_valid_i = '0; mst_w_last_i = '0; mst_b_ready_i = '0;
        slv_aw_ready_i = 1'b0; slv_w_ready_i = 1'b0; slv_b_valid_i = 1'b0;
        @(posedge clk_i); #1;
        repeat (3) checkOutput();
        rst_ni = 1'b1;
        #1;
        check("reset_outstanding", 32'(outstanding_o), 32'd0);

        // Masters 1 and 3 request with rr_ptr at 0: 1 first, then 3.
        mst_aw_valid_i = 4'b1010; slv_aw_ready_i = 1'b1;
        checkOutput();
        #1;
        check("first_grant_sel", 32'(aw_sel_o), 32'd1);
        check("first_grant_awvalid", 32'(slv_aw_valid_o), 32'd1);
        checkOutput();
        mst_w_valid_i = 4'b0010; mst_w_last_i = 4'b0010; slv_w_ready_i = 1'b1;
        checkOutput();
        checkOutput();
        #1;
        check("second_grant_sel", 32'(aw_sel_o), 32'd3);
        checkOutput();
        mst_w_valid_i = 4'b1000; mst_w_last_i = 4'b1000;
        checkOutput();
        mst_aw_valid_i = '0; mst_w_valid_i = '0;
        slv_b_valid_i = 1'b1; mst_b_ready_i = 4'b1111;
        #1;
        check("b_route_first", 32'(mst_b_valid_o), 32'(4'b0010));
        checkOutput();
        #1;
        check("b_route_second", 32'(mst_b_valid_o), 32'(4'b1000));
        checkOutput();
        slv_b_valid_i = 1'b0;

        // Fill the B-route FIFO with the slave withholding B.
        mst_aw_valid_i = 4'b1111; mst_w_valid_i = 4'b1111; mst_w_last_i = 4'b1111;
        repeat (24) checkOutput();
        repeat (3) checkOutput();
        #1;
        check("full_outstanding", 32'(outstanding_o), 32'd8);
        check("full_no_aw_ready", 32'(mst_aw_ready_o), 32'd0);
        slv_b_valid_i = 1'b1;
        checkOutput();
        slv_b_valid_i = 1'b0;
        #1;
        check("after_pop_outstanding", 32'(outstanding_o), 32'd7);
        checkOutput();
        #1;
        check("after_pop_grant", 32'(slv_aw_valid_o), 32'd1);
        checkOutput();
        checkOutput();

        // Reset in the middle of a burst with three writes outstanding.
        rst_ni = 1'b0;
        checkOutput();
        rst_ni = 1'b1;
        repeat (6) checkOutput();
        mst_w_valid_i = '0;
        repeat (2) checkOutput();
        #1;
        check("pre_reset_outstanding", 32'(outstanding_o), 32'd3);
        rst_ni = 1'b0;
        checkOutput();
        rst_ni = 1'b1; mst_w_valid_i = 4'b1111;
        #1;
        check("post_reset_outstanding", 32'(outstanding_o), 32'd0);
        check("post_reset_w_ready", 32'(mst_w_ready_o), 32'd0);
        check("post_reset_w_valid", 32'(slv_w_valid_o), 32'd0);

        // W from master 2 held off until its AW completes, then a 4-beat burst.
        mst_aw_valid_i = 4'b0100; mst_w_valid_i = 4'b0100; mst_w_last_i = '0;
        slv_aw_ready_i = 1'b0; slv_w_ready_i = 1'b1;
        checkOutput();
        #1;
        check("early_w_ready", 32'(mst_w_ready_o), 32'd0);
        checkOutput();
        slv_aw_ready_i = 1'b1;
        checkOutput();
        repeat (3) checkOutput();
        #1;
        check("burst_still_data", 32'(slv_w_valid_o), 32'd1);
        mst_w_last_i = 4'b0100;
        checkOutput();
        #1;
        check("burst_done_w_valid", 32'(slv_w_valid_o), 32'd0);

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus();
            checkOutput();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
